// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two result sources (EX and SLB) share one
// registered broadcast path to the ROB, the RS and the SLB. Each source has a
// small skid FIFO and a round-robin pointer settles simultaneous requests.
module cdb_arbiter #(
    parameter int NICK_W     = 5,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              iclr,
    input  logic              iEX_en,
    input  logic [NICK_W-1:0] iEX_nick,
    input  logic [DATA_W-1:0] iEX_dt,
    input  logic              iEX_ac,
    input  logic [ADDR_W-1:0] iEX_j_pc,
    output logic              oEX_stall,
    input  logic              iSLB_en,
    input  logic [NICK_W-1:0] iSLB_nick,
    input  logic [DATA_W-1:0] iSLB_dt,
    output logic              oSLB_stall,
    output logic              oCDB_en,
    output logic              oCDB_src,
    output logic [NICK_W-1:0] oCDB_nick,
    output logic [DATA_W-1:0] oCDB_dt,
    output logic              oCDB_ac,
    output logic [ADDR_W-1:0] oCDB_j_pc,
    output logic              oERR
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Round-robin pointer: which source wins when both have a candidate
    typedef enum logic {
        RR_EX  = 1'b0,
        RR_SLB = 1'b1
    } rr_t;

    rr_t rr_ptr;

    // EX skid FIFO storage and bookkeeping
    logic [NICK_W-1:0] ex_nick_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] ex_dt_mem   [FIFO_DEPTH];
    logic              ex_ac_mem   [FIFO_DEPTH];
    logic [ADDR_W-1:0] ex_pc_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]  ex_rd;
    logic [PTR_W-1:0]  ex_wr;
    logic [CNT_W-1:0]  ex_cnt;

    // SLB skid FIFO storage and bookkeeping
    logic [NICK_W-1:0] slb_nick_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] slb_dt_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]  slb_rd;
    logic [PTR_W-1:0]  slb_wr;
    logic [CNT_W-1:0]  slb_cnt;

    logic ex_head_vld;
    logic slb_head_vld;
    logic ex_in_ok;
    logic slb_in_ok;
    logic ex_bad;
    logic slb_bad;
    logic ex_cand;
    logic slb_cand;
    logic grant_ex;
    logic grant_slb;
    logic ex_push;
    logic ex_pop;
    logic slb_push;
    logic slb_pop;
    logic advance;

    logic              win_src;
    logic [NICK_W-1:0] win_nick;
    logic [DATA_W-1:0] win_dt;
    logic              win_ac;
    logic [ADDR_W-1:0] win_pc;

    // Stall comes straight from the registered occupancy
    assign oEX_stall  = (ex_cnt == FULL_CNT);
    assign oSLB_stall = (slb_cnt == FULL_CNT);

    // An edge only does useful work when enabled and not flushing
    assign advance = rdy && !iclr;

    // Classify live inputs, pick candidates, and arbitrate between them
    always_comb begin
        ex_head_vld  = (ex_cnt != '0);
        slb_head_vld = (slb_cnt != '0);

        ex_in_ok  = iEX_en && !oEX_stall && (iEX_nick != '0);
        slb_in_ok = iSLB_en && !oSLB_stall && (iSLB_nick != '0);
        ex_bad    = iEX_en && (oEX_stall || (iEX_nick == '0));
        slb_bad   = iSLB_en && (oSLB_stall || (iSLB_nick == '0));

        ex_cand  = ex_head_vld || ex_in_ok;
        slb_cand = slb_head_vld || slb_in_ok;

        grant_ex  = ex_cand && (!slb_cand || (rr_ptr == RR_EX));
        grant_slb = slb_cand && (!ex_cand || (rr_ptr == RR_SLB));

        ex_pop   = grant_ex && ex_head_vld;
        slb_pop  = grant_slb && slb_head_vld;
        ex_push  = ex_in_ok && (ex_head_vld || !grant_ex);
        slb_push = slb_in_ok && (slb_head_vld || !grant_slb);
    end

    // Steer the winning result (FIFO head or bypassed live input) to the bus
    always_comb begin
        win_src  = 1'b0;
        win_nick = '0;
        win_dt   = '0;
        win_ac   = 1'b0;
        win_pc   = '0;
        if (grant_ex) begin
            win_src = 1'b0;
            if (ex_head_vld) begin
                win_nick = ex_nick_mem[ex_rd];
                win_dt   = ex_dt_mem[ex_rd];
                win_ac   = ex_ac_mem[ex_rd];
                win_pc   = ex_pc_mem[ex_rd];
            end else begin
                win_nick = iEX_nick;
                win_dt   = iEX_dt;
                win_ac   = iEX_ac;
                win_pc   = iEX_j_pc;
            end
        end else if (grant_slb) begin
            win_src = 1'b1;
            if (slb_head_vld) begin
                win_nick = slb_nick_mem[slb_rd];
                win_dt   = slb_dt_mem[slb_rd];
            end else begin
                win_nick = iSLB_nick;
                win_dt   = iSLB_dt;
            end
        end
    end

    // EX FIFO payload write; storage needs no reset since count gates reads
    always_ff @(posedge clk) begin
        if (advance && ex_push) begin
            ex_nick_mem[ex_wr] <= iEX_nick;
            ex_dt_mem[ex_wr]   <= iEX_dt;
            ex_ac_mem[ex_wr]   <= iEX_ac;
            ex_pc_mem[ex_wr]   <= iEX_j_pc;
        end
    end

    // SLB FIFO payload write
    always_ff @(posedge clk) begin
        if (advance && slb_push) begin
            slb_nick_mem[slb_wr] <= iSLB_nick;
            slb_dt_mem[slb_wr]   <= iSLB_dt;
        end
    end

    // EX FIFO pointers and occupancy; pointers wrap naturally at the depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd  <= '0;
            ex_wr  <= '0;
            ex_cnt <= '0;
        end else if (rdy) begin
            if (iclr) begin
                ex_rd  <= '0;
                ex_wr  <= '0;
                ex_cnt <= '0;
            end else begin
                if (ex_pop) begin
                    ex_rd <= ex_rd + 1'b1;
                end
                if (ex_push) begin
                    ex_wr <= ex_wr + 1'b1;
                end
                if (ex_push && !ex_pop) begin
                    ex_cnt <= ex_cnt + 1'b1;
                end else if (ex_pop && !ex_push) begin
                    ex_cnt <= ex_cnt - 1'b1;
                end
            end
        end
    end

    // SLB FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slb_rd  <= '0;
            slb_wr  <= '0;
            slb_cnt <= '0;
        end else if (rdy) begin
            if (iclr) begin
                slb_rd  <= '0;
                slb_wr  <= '0;
                slb_cnt <= '0;
            end else begin
                if (slb_pop) begin
                    slb_rd <= slb_rd + 1'b1;
                end
                if (slb_push) begin
                    slb_wr <= slb_wr + 1'b1;
                end
                if (slb_push && !slb_pop) begin
                    slb_cnt <= slb_cnt + 1'b1;
                end else if (slb_pop && !slb_push) begin
                    slb_cnt <= slb_cnt - 1'b1;
                end
            end
        end
    end

    // Round-robin pointer flips only when both sources contended
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= RR_EX;
        end else if (rdy) begin
            if (iclr) begin
                rr_ptr <= RR_EX;
            end else if (ex_cand && slb_cand) begin
                rr_ptr <= (rr_ptr == RR_EX) ? RR_SLB : RR_EX;
            end
        end
    end

    // Registered broadcast; payload fields hold between results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oCDB_en   <= 1'b0;
            oCDB_src  <= 1'b0;
            oCDB_nick <= '0;
            oCDB_dt   <= '0;
            oCDB_ac   <= 1'b0;
            oCDB_j_pc <= '0;
        end else if (!advance) begin
            oCDB_en <= 1'b0;
        end else begin
            oCDB_en <= grant_ex || grant_slb;
            if (grant_ex || grant_slb) begin
                oCDB_src  <= win_src;
                oCDB_nick <= win_nick;
                oCDB_dt   <= win_dt;
                oCDB_ac   <= win_ac;
                oCDB_j_pc <= win_pc;
            end
        end
    end

    // Sticky error for dropped inputs (sent while stalled, or with tag 0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oERR <= 1'b0;
        end else if (advance && (ex_bad || slb_bad)) begin
            oERR <= 1'b1;
        end
    end

endmodule
